pipe_hazard_tracker: RTL and testbench

Sequential counterpart to the ID-stage control decoder. Carries each decoded instruction's control bits through the ID/EX, EX/MEM and MEM/WB control registers. Resolves conditional branches in EX and returns the in-flight status the decoder uses for forwarding, load-stall and squash decisions: ern, ewreg, em2reg, mrn, mwreg, ex_is_cond, ex_is_uncond and mem_is_cond. It also keeps saturating stall and flush counters for the debug bus.

---
 rtl/pipe_hazard_tracker_pkg.sv | 24 ++
 rtl/pipe_hazard_tracker_sat_counter.sv | 34 +++
 rtl/pipe_hazard_tracker.sv | 144 ++++++++++++++
 tb/tb_pipe_hazard_tracker.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_tracker_pkg
// Description : Shared widths and the per-instruction control bundle carried
//               down the pipeline (also used by the ID-stage decoder).
// Revision    : 1.0  initial release
// ============================================================================
package pipe_hazard_tracker_pkg;

    localparam int RN_W  = 5;
    localparam int CNT_W = 16;

    // Control bits that travel with an instruction from ID onward.
    typedef struct packed {
        logic            wreg;
        logic            m2reg;
        logic            wmem;
        logic [RN_W-1:0] rn;
    } ctrl_t;

    localparam ctrl_t C_CTRL_BUBBLE = '{wreg: 1'b0, m2reg: 1'b0, wmem: 1'b0, rn: '0};

endpackage : pipe_hazard_tracker_pkg
`default_nettype wire

// File: rtl/pipe_hazard_tracker_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : pipe_sat_counter
// Description : Up-counter with synchronous enable and asynchronous clear that
//               holds at all-ones instead of wrapping.
// Revision    : 1.0  initial release
// ============================================================================
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] count
);
    import pipe_hazard_tracker_pkg::*;

    localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_count;

    // Count enabled events, sticking at the maximum value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (en && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + C_ONE;
        end
    end

    assign count = r_count;

endmodule : pipe_sat_counter
`default_nettype wire

// File: rtl/pipe_hazard_tracker.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_tracker
// Description : ID/EX, EX/MEM and MEM/WB control registers, EX-stage branch
//               resolution, and saturating stall/flush counters. Feeds the
//               in-flight status the decoder needs for forwarding, load-stall
//               and squash decisions.
// Revision    : 1.0  initial release
// ============================================================================
module pipe_hazard_tracker #(
    // RN_W must match the package width, since the control bundle uses it.
    parameter int RN_W  = pipe_hazard_tracker_pkg::RN_W,
    parameter int CNT_W = pipe_hazard_tracker_pkg::CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_wreg,
    input  logic             id_m2reg,
    input  logic             id_wmem,
    input  logic [RN_W-1:0]  id_rn,
    input  logic             id_beq,
    input  logic             id_bne,
    input  logic             id_uncond,
    input  logic             we_pc_ir,
    input  logic             ex_zero,
    output logic [RN_W-1:0]  ern,
    output logic             ewreg,
    output logic             em2reg,
    output logic             ewmem,
    output logic [RN_W-1:0]  mrn,
    output logic             mwreg,
    output logic             mm2reg,
    output logic             mwmem,
    output logic [RN_W-1:0]  wrn,
    output logic             wwreg,
    output logic             wm2reg,
    output logic             ex_is_cond,
    output logic             ex_is_uncond,
    output logic             mem_is_cond,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    import pipe_hazard_tracker_pkg::*;

    ctrl_t r_ex;
    ctrl_t r_mem;
    ctrl_t r_wb;
    ctrl_t w_cap;
    logic  r_ebeq;
    logic  r_ebne;
    logic  r_ex_uncond;
    logic  r_mem_cond;
    logic  w_cap_beq;
    logic  w_cap_bne;
    logic  w_cap_uncond;
    logic  w_load_stall;
    logic  w_bubble;
    logic  w_kill;
    logic  w_ex_cond;

    // A stalled ID stage that is not holding a branch means a load-use stall.
    assign w_load_stall = ~we_pc_ir & ~id_beq & ~id_bne;
    assign w_ex_cond    = (r_ebeq & ex_zero) | (r_ebne & ~ex_zero);
    assign w_bubble     = w_load_stall | w_ex_cond;
    // Delay-slot style kill: the instruction after a jump or taken branch
    // may flow on but must not write anything.
    assign w_kill       = r_ex_uncond | r_mem_cond;

    // Build the next ID/EX contents: bubble, killed write, or the decoded bits.
    always_comb begin
        w_cap        = C_CTRL_BUBBLE;
        w_cap_beq    = 1'b0;
        w_cap_bne    = 1'b0;
        w_cap_uncond = 1'b0;
        if (!w_bubble) begin
            w_cap.wreg   = id_wreg & ~w_kill & (id_rn != '0);
            w_cap.m2reg  = id_m2reg;
            w_cap.wmem   = id_wmem & ~w_kill;
            w_cap.rn     = id_rn;
            w_cap_beq    = id_beq;
            w_cap_bne    = id_bne;
            w_cap_uncond = id_uncond;
        end
    end

    // ID/EX register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ex        <= C_CTRL_BUBBLE;
            r_ebeq      <= 1'b0;
            r_ebne      <= 1'b0;
            r_ex_uncond <= 1'b0;
        end else begin
            r_ex        <= w_cap;
            r_ebeq      <= w_cap_beq;
            r_ebne      <= w_cap_bne;
            r_ex_uncond <= w_cap_uncond;
        end
    end

    // EX/MEM and MEM/WB registers shift every cycle; these stages never stall.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mem      <= C_CTRL_BUBBLE;
            r_wb       <= C_CTRL_BUBBLE;
            r_mem_cond <= 1'b0;
        end else begin
            r_mem      <= r_ex;
            r_wb       <= r_mem;
            r_mem_cond <= w_ex_cond;
        end
    end

    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .en    (w_load_stall),
        .count (stall_cnt)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .en    (w_ex_cond | r_ex_uncond),
        .count (flush_cnt)
    );

    assign ern          = r_ex.rn;
    assign ewreg        = r_ex.wreg;
    assign em2reg       = r_ex.m2reg;
    assign ewmem        = r_ex.wmem;
    assign mrn          = r_mem.rn;
    assign mwreg        = r_mem.wreg;
    assign mm2reg       = r_mem.m2reg;
    assign mwmem        = r_mem.wmem;
    assign wrn          = r_wb.rn;
    assign wwreg        = r_wb.wreg;
    assign wm2reg       = r_wb.m2reg;
    assign ex_is_cond   = w_ex_cond;
    assign ex_is_uncond = r_ex_uncond;
    assign mem_is_cond  = r_mem_cond;

endmodule : pipe_hazard_tracker
`default_nettype wire

// File: tb/tb_pipe_hazard_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_tracker
// Description : Directed self-checking bench for pipe_hazard_tracker.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_tracker;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        id_wreg = 1'b0;
    logic        id_m2reg = 1'b0;
    logic        id_wmem = 1'b0;
    logic [4:0]  id_rn = '0;
    logic        id_beq = 1'b0;
    logic        id_bne = 1'b0;
    logic        id_uncond = 1'b0;
    logic        we_pc_ir = 1'b1;
    logic        ex_zero = 1'b0;
    logic [4:0]  ern, mrn, wrn;
    logic        ewreg, em2reg, ewmem, mwreg, mm2reg, mwmem, wwreg, wm2reg;
    logic        ex_is_cond, ex_is_uncond, mem_is_cond;
    logic [15:0] stall_cnt, flush_cnt;

    int n_pass  = 0;
    int n_total = 0;

    pipe_hazard_tracker #(.RN_W(5), .CNT_W(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .id_wreg      (id_wreg),
        .id_m2reg     (id_m2reg),
        .id_wmem      (id_wmem),
        .id_rn        (id_rn),
        .id_beq       (id_beq),
        .id_bne       (id_bne),
        .id_uncond    (id_uncond),
        .we_pc_ir     (we_pc_ir),
        .ex_zero      (ex_zero),
        .ern          (ern),
        .ewreg        (ewreg),
        .em2reg       (em2reg),
        .ewmem        (ewmem),
        .mrn          (mrn),
        .mwreg        (mwreg),
        .mm2reg       (mm2reg),
        .mwmem        (mwmem),
        .wrn          (wrn),
        .wwreg        (wwreg),
        .wm2reg       (wm2reg),
        .ex_is_cond   (ex_is_cond),
        .ex_is_uncond (ex_is_uncond),
        .mem_is_cond  (mem_is_cond),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic set_id(input logic wr, input logic m2, input logic wm, input logic [4:0] rn,
                          input logic beq, input logic bne, input logic unc);
        id_wreg = wr; id_m2reg = m2; id_wmem = wm; id_rn = rn;
        id_beq = beq; id_bne = bne; id_uncond = unc;
    endtask

    // Every output packed together; all-zero after reset.
    function automatic logic [31:0] all_outs();
        return {ern, mrn, wrn, ewreg, em2reg, ewmem, mwreg, mm2reg, mwmem,
                wwreg, wm2reg, ex_is_cond, ex_is_uncond, mem_is_cond};
    endfunction

    initial begin
        // Reset state
        step(3);
        chk("reset_outs", all_outs(), 32'h0);
        chk("reset_stall_cnt", {16'h0, stall_cnt}, 32'h0);
        chk("reset_flush_cnt", {16'h0, flush_cnt}, 32'h0);
        reset = 1'b0;

        // Single add r8 flows E -> M -> W
        set_id(1'b1, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0);
        step();
        chk("add_e", {ern, ewreg, em2reg, ewmem}, {5'd8, 3'b100});
        set_id(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk("add_m", {mrn, mwreg, mm2reg, mwmem}, {5'd8, 3'b100});
        chk("add_e_next", {ern, ewreg}, {5'd0, 1'b0});
        step();
        chk("add_w", {wrn, wwreg, wm2reg}, {5'd8, 2'b10});
        chk("add_flags", {ex_is_cond, ex_is_uncond, mem_is_cond}, 32'h0);

        // lw r5 then a one-cycle load stall
        set_id(1'b1, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);
        step();
        chk("lw_e", {ern, ewreg, em2reg}, {5'd5, 2'b11});
        set_id(1'b1, 1'b0, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0);
        we_pc_ir = 1'b0;
        step();
        chk("stall_bubble", {ern, ewreg, em2reg, ewmem}, {5'd0, 3'b000});
        chk("stall_cnt_1", {16'h0, stall_cnt}, 32'd1);
        chk("stall_lw_m", {mrn, mm2reg}, {5'd5, 1'b1});
        we_pc_ir = 1'b1;
        set_id(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();

        // beq taken in EX
        set_id(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        step();
        set_id(1'b1, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0);
        ex_zero = 1'b1;
        #1;
        chk("beq_ex_cond", {31'h0, ex_is_cond}, 32'd1);
        chk("beq_flush_before", {16'h0, flush_cnt}, 32'd0);
        step();
        chk("beq_mem_cond", {31'h0, mem_is_cond}, 32'd1);
        chk("beq_squash", {ern, ewreg}, {5'd0, 1'b0});
        chk("beq_flush_cnt", {16'h0, flush_cnt}, 32'd1);
        set_id(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        ex_zero = 1'b0;
        step();
        chk("beq_mem_clear", {31'h0, mem_is_cond}, 32'd0);

        // bne not taken (ex_zero = 1)
        set_id(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step();
        set_id(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        ex_zero = 1'b1;
        #1;
        chk("bne_ex_cond", {31'h0, ex_is_cond}, 32'd0);
        step();
        chk("bne_mem_cond", {31'h0, mem_is_cond}, 32'd0);
        chk("bne_flush_cnt", {16'h0, flush_cnt}, 32'd1);
        ex_zero = 1'b0;

        // jal r31 then a writing instruction that must be killed
        set_id(1'b1, 1'b0, 1'b0, 5'd31, 1'b0, 1'b0, 1'b1);
        step();
        chk("jal_e", {ern, ewreg, ex_is_uncond}, {5'd31, 2'b11});
        set_id(1'b1, 1'b0, 1'b1, 5'd10, 1'b0, 1'b0, 1'b0);
        step();
        chk("jal_kill", {ern, ewreg, ewmem, ex_is_uncond}, {5'd10, 3'b000});
        chk("jal_flush_cnt", {16'h0, flush_cnt}, 32'd2);

        // Destination r0 never writes; store flows to MEM
        set_id(1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk("r0_wreg", {ern, ewreg, ewmem}, {5'd0, 2'b01});
        set_id(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk("sw_m", {mwreg, mwmem}, 32'b01);

        // Hold load stall long enough to saturate stall_cnt (starts at 1)
        we_pc_ir = 1'b0;
        step(65533);
        chk("stall_cnt_65534", {16'h0, stall_cnt}, 32'd65534);
        step();
        chk("stall_cnt_sat", {16'h0, stall_cnt}, 32'd65535);
        step(4466);
        chk("stall_cnt_hold", {16'h0, stall_cnt}, 32'd65535);
        chk("flush_cnt_kept", {16'h0, flush_cnt}, 32'd2);

        // Reset mid-pipeline, asynchronous
        we_pc_ir = 1'b1;
        set_id(1'b1, 1'b0, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0);
        step(2);
        chk("pre_reset_m", {mrn, mwreg}, {5'd7, 1'b1});
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_outs", all_outs(), 32'h0);
        chk("async_reset_cnts", {stall_cnt, flush_cnt}, 32'h0);
        step();
        chk("reset_held_outs", all_outs(), 32'h0);
        reset = 1'b0;
        step();
        chk("post_reset_e", {ern, ewreg, mrn, mwreg}, {5'd7, 1'b1, 5'd0, 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_pipe_hazard_tracker
`default_nettype wire
